stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control FSM and BCD time accumulator for the stopwatch. It consumes the one-cycle `rollover` pulse of the 10 ms prescaler as `tick` and gates counting with start/stop/lap/reset commands. It also drives a one-cycle clear back to the prescaler so every start or resume begins on a full 10 ms period. Its display bus feeds the seven-segment mux directly.

## Interface
- `MIN_LIMIT`, default 59: highest displayed minute value (00..99 legal); wrap point is MIN_LIMIT:59.99.

Ports:
- `clk`  in  1  system clock, same domain as the prescaler.
- `reset`  in  1  synchronous, active-high; sampled on posedge clk.
- `tick`  in  1  10 ms pulse, one cycle wide (prescaler `rollover`).
- `start_stop`  in  1  debounced single-cycle command pulse.
- `lap_reset`  in  1  debounced single-cycle command pulse.
- `disp_bcd`  out  24  display digits, in 4-bit BCD nibbles: [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] cs tens, [3:0] cs ones.
- `state`  out  2  IDLE=0, RUN=1, LAP=2, STOP=3.
- `running`  out  1  high in RUN or LAP.
- `timer_clr`  out  1  one-cycle clear request to the prescaler.
- `overflow`  out  1  one-cycle pulse on wrap.

## Operation
- Internal live count is six BCD digits (`live`). The display latch `hold` has the same format.
- `disp_bcd` equals `hold` in LAP and `live` in all other states.
- FSM transitions:
  - IDLE: start_stop -> RUN. lap_reset is ignored.
  - RUN: start_stop -> STOP. lap_reset -> LAP, and `hold` is loaded with `live` including any increment on that same edge.
  - LAP: start_stop -> STOP; display returns to live. lap_reset -> LAP, reloading `hold` with the current `live` (new lap split).
  - STOP: start_stop -> RUN (resume). lap_reset -> IDLE, clearing `live` and `hold` to zero.
- Command priority: start_stop and lap_reset in the same cycle -> start_stop acts, lap_reset is dropped.
- Counting happens only when the state is RUN or LAP at the sampling edge, and `tick`=1.
- Increment chain:
  - cs ones 0..9, carry into cs tens 0..9.
  - Carry into sec ones 0..9, then sec tens 0..5.
  - Carry into min ones / min tens, up to MIN_LIMIT.
- Every digit stays valid BCD: no nibble ever exceeds 9, and sec tens never exceeds 5.
- Wrap: a tick at MIN_LIMIT:59.99 -> 00:00.00, with `overflow`=1 for one cycle. Counting continues in the current state.
- `timer_clr` pulses on the IDLE->RUN and STOP->RUN transitions only.

## Timing
- All outputs are registered. Command effects appear on outputs the cycle after the sampling edge.
- tick to `disp_bcd` latency: 1 cycle.
- `timer_clr` is high for exactly the one cycle after the edge that accepted start_stop. The prescaler's next rollover is therefore a full period later.
- tick and start_stop coincide:
  - In RUN/LAP: the tick is counted, then the FSM enters STOP (count includes that tick).
  - In IDLE/STOP: the tick is ignored.
- tick and lap_reset coincide in RUN: `hold` captures the incremented value.
- Reset values:
  - `state`=IDLE, `live`=`hold`=0, `disp_bcd`=0.
  - `running`=0, `timer_clr`=0, `overflow`=0.
- Reset mid-run returns to IDLE and zeroes everything regardless of tick or commands in the same cycle. Reset has priority over all inputs.
- `tick` asserted on consecutive cycles is legal, and each cycle counts once.

## Test plan
- Reset, then start_stop, then 150 ticks -> `disp_bcd`=00:01.50, `state`=RUN, `timer_clr` pulsed exactly once, 1 cycle after start_stop.
- In RUN at 00:03.27, assert lap_reset; then 100 ticks -> `disp_bcd` holds 00:03.27. Then start_stop -> state STOP, display shows live 00:04.27.
- From STOP at 00:04.27, assert lap_reset -> IDLE, display 00:00.00. Then assert start_stop and lap_reset in the same cycle -> RUN; lap ignored.
- Preload to 59:59.99 via ticks (MIN_LIMIT=59), then one tick -> 00:00.00, `overflow` high for exactly 1 cycle, state unchanged.
- tick coincident with start_stop in RUN at 00:00.09 -> display 00:00.10, STOP. Then tick coincident with start_stop in STOP -> display stays 00:00.10, RUN.
- Assert reset during RUN at 12:34.56 with a simultaneous tick -> next cycle all outputs zero, state IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and six-digit BCD time accumulator (mm:ss.cc).
// Counts 10 ms ticks from the prescaler, handles start/stop/lap/reset
// commands, and asks the prescaler to clear whenever counting (re)starts.
module stopwatch_ctrl #(
    parameter int MIN_LIMIT = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap_reset,
    output logic [23:0] disp_bcd,
    output logic [1:0]  state,
    output logic        running,
    output logic        timer_clr,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    // Minute value at which the count wraps, split into BCD digits.
    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

    state_t      r_state;
    logic [23:0] r_live;
    logic [23:0] r_hold;
    logic [23:0] r_disp;
    logic        r_running;
    logic        r_timer_clr;
    logic        r_overflow;

    logic        w_count;
    logic        w_at_max;
    logic        w_wrap;
    logic [23:0] w_live_inc;
    logic [23:0] w_live_cnt;

    // BCD increment of the live count, carrying digit by digit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_live_inc = r_live;
        w_at_max   = 1'b0;
        if (r_live[3:0] != 4'd9) begin
            w_live_inc[3:0] = r_live[3:0] + 4'd1;
        end else begin
            w_live_inc[3:0] = 4'd0;
            if (r_live[7:4] != 4'd9) begin
                w_live_inc[7:4] = r_live[7:4] + 4'd1;
            end else begin
                w_live_inc[7:4] = 4'd0;
                if (r_live[11:8] != 4'd9) begin
                    w_live_inc[11:8] = r_live[11:8] + 4'd1;
                end else begin
                    w_live_inc[11:8] = 4'd0;
                    if (r_live[15:12] != 4'd5) begin
                        w_live_inc[15:12] = r_live[15:12] + 4'd1;
                    end else begin
                        w_live_inc[15:12] = 4'd0;
                        if (r_live[23:16] == {LIM_TENS, LIM_ONES}) begin
                            w_live_inc[23:16] = 8'd0;
                            w_at_max          = 1'b1;
                        end else if (r_live[19:16] != 4'd9) begin
                            w_live_inc[19:16] = r_live[19:16] + 4'd1;
                        end else begin
                            w_live_inc[19:16] = 4'd0;
                            w_live_inc[23:20] = r_live[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Tick qualification: only RUN and LAP accumulate time.
    always_comb begin
        w_count    = tick && ((r_state == RUN) || (r_state == LAP));
        w_wrap     = w_count && w_at_max;
        w_live_cnt = w_count ? w_live_inc : r_live;
    end

    // Control FSM with registered count, lap latch and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_live      <= 24'd0;
            r_hold      <= 24'd0;
            r_disp      <= 24'd0;
            r_running   <= 1'b0;
            r_timer_clr <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            r_live      <= w_live_cnt;
            r_overflow  <= w_wrap;
            r_timer_clr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_disp <= r_live;
                    if (start_stop) begin
                        r_state     <= RUN;
                        r_running   <= 1'b1;
                        r_timer_clr <= 1'b1;
                    end
                end
                RUN: begin
                    r_disp <= w_live_cnt;
                    if (start_stop) begin
                        r_state   <= STOP;
                        r_running <= 1'b0;
                    end else if (lap_reset) begin
                        r_state <= LAP;
                        r_hold  <= w_live_cnt;
                    end
                end
                LAP: begin
                    r_disp <= r_hold;
                    if (start_stop) begin
                        r_state   <= STOP;
                        r_running <= 1'b0;
                        r_disp    <= w_live_cnt;
                    end else if (lap_reset) begin
                        r_hold <= w_live_cnt;
                        r_disp <= w_live_cnt;
                    end
                end
                STOP: begin
                    r_disp <= r_live;
                    if (start_stop) begin
                        r_state     <= RUN;
                        r_running   <= 1'b1;
                        r_timer_clr <= 1'b1;
                    end else if (lap_reset) begin
                        r_state <= IDLE;
                        r_live  <= 24'd0;
                        r_hold  <= 24'd0;
                        r_disp  <= 24'd0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_disp    <= 24'd0;
                end
            endcase
        end
    end

    assign disp_bcd  = r_disp;
    assign state     = r_state;
    assign running   = r_running;
    assign timer_clr = r_timer_clr;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl. Two instances share stimulus:
// dut wraps at 10:59.99 so the wrap is reachable in a short run, dut59
// uses the default limit and must carry past that point without wrapping.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        start_stop;
    logic        lap_reset;
    logic [23:0] disp_bcd,  disp_bcd59;
    logic [1:0]  state,     state59;
    logic        running,   running59;
    logic        timer_clr, timer_clr59;
    logic        overflow,  overflow59;

    int n_checks = 0;
    int n_errors = 0;
    int clr_cnt  = 0;
    int ovf_cnt  = 0;

    stopwatch_ctrl #(.MIN_LIMIT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .disp_bcd   (disp_bcd),
        .state      (state),
        .running    (running),
        .timer_clr  (timer_clr),
        .overflow   (overflow)
    );

    stopwatch_ctrl dut59 (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .disp_bcd   (disp_bcd59),
        .state      (state59),
        .running    (running59),
        .timer_clr  (timer_clr59),
        .overflow   (overflow59)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (timer_clr) clr_cnt++;
        if (overflow)  ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are valid on return.
    task automatic step(input logic t, input logic ss, input logic lr);
        tick = t; start_stop = ss; lap_reset = lr;
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
    endtask

    // n consecutive tick cycles.
    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_disp",  32'(disp_bcd),  32'h0);
        check("rst_state", 32'(state),     32'd0);
        check("rst_run",   32'(running),   32'd0);
        check("rst_clr",   32'(timer_clr), 32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b0;
        clr_cnt = 0;

        // Start and count 150 ticks.
        step(1'b0, 1'b1, 1'b0);
        check("start_state", 32'(state),     32'd1);
        check("start_clr",   32'(timer_clr), 32'd1);
        check("start_run",   32'(running),   32'd1);
        ticks(150);
        check("t150_disp",   32'(disp_bcd),  32'h000150);
        check("t150_state",  32'(state),     32'd1);
        check("t150_clr",    32'(timer_clr), 32'd0);
        check("clr_once",    32'(clr_cnt),   32'd1);

        // Lap split at 00:03.27, display frozen while live keeps running.
        ticks(177);
        check("t327_disp",   32'(disp_bcd),  32'h000327);
        step(1'b0, 1'b0, 1'b1);
        check("lap_state",   32'(state),     32'd2);
        check("lap_disp",    32'(disp_bcd),  32'h000327);
        ticks(100);
        check("lap_hold",    32'(disp_bcd),  32'h000327);
        check("lap_run",     32'(running),   32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("stop_state",  32'(state),     32'd3);
        check("stop_disp",   32'(disp_bcd),  32'h000427);
        check("stop_run",    32'(running),   32'd0);
        check("stop_clr",    32'(timer_clr), 32'd0);

        // Clear from STOP, then simultaneous commands: start wins.
        step(1'b0, 1'b0, 1'b1);
        check("clr_state",   32'(state),     32'd0);
        check("clr_disp",    32'(disp_bcd),  32'h0);
        step(1'b0, 1'b1, 1'b1);
        check("both_state",  32'(state),     32'd1);
        check("both_clr",    32'(timer_clr), 32'd1);
        check("both_disp",   32'(disp_bcd),  32'h0);
        check("both_59",     32'(state59),   32'd1);

        // Long run to the wrap point of the small-limit instance.
        ticks(59999);
        check("m9_disp",     32'(disp_bcd),   32'h095999);
        ticks(1);
        check("m10_disp",    32'(disp_bcd),   32'h100000);
        check("m10_disp59",  32'(disp_bcd59), 32'h100000);
        ticks(5999);
        check("max_disp",    32'(disp_bcd),   32'h105999);
        check("max_ovf",     32'(overflow),   32'd0);
        ticks(1);
        check("wrap_disp",   32'(disp_bcd),   32'h000000);
        check("wrap_ovf",    32'(overflow),   32'd1);
        check("wrap_state",  32'(state),      32'd1);
        check("nowrap_59",   32'(disp_bcd59), 32'h110000);
        check("nowrap_ovf",  32'(overflow59), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_drop",    32'(overflow),   32'd0);
        check("ovf_once",    32'(ovf_cnt),    32'd1);

        // Tick coincident with start_stop in RUN then in STOP.
        ticks(9);
        check("t09_disp",    32'(disp_bcd),   32'h000009);
        step(1'b1, 1'b1, 1'b0);
        check("tss_disp",    32'(disp_bcd),   32'h000010);
        check("tss_state",   32'(state),      32'd3);
        check("tss_disp59",  32'(disp_bcd59), 32'h110010);
        step(1'b1, 1'b1, 1'b0);
        check("res_disp",    32'(disp_bcd),   32'h000010);
        check("res_state",   32'(state),      32'd1);
        check("res_clr",     32'(timer_clr),  32'd1);

        // Reset mid-run with a coincident tick and command.
        ticks(5);
        reset = 1'b1; tick = 1'b1; start_stop = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; start_stop = 1'b0;
        check("mrst_disp",   32'(disp_bcd),   32'h0);
        check("mrst_state",  32'(state),      32'd0);
        check("mrst_run",    32'(running),    32'd0);
        check("mrst_clr",    32'(timer_clr),  32'd0);
        check("mrst_ovf",    32'(overflow),   32'd0);
        check("mrst_disp59", 32'(disp_bcd59), 32'h0);
        check("mrst_st59",   32'(state59),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
